// File: rtl/keysw_device.sv
// keysw_device: memory-mapped push-button / slide-switch peripheral.
// KDATA/KCTRL at ADDRKEY/ADDRKEY+4, SDATA/SCTRL at ADDRSW/ADDRSW+4.
// CTRL layout: bit4 IE, bit2 OVR, bit0 RDY. intr = (KRDY&KIE)|(SRDY&SIE), registered.
// Build option: define KEYSW_DEBOUNCE_EN to require DEBOUNCE_CYCLES stable
// edges before a data register loads; otherwise it loads on the first differing
// synchronized sample.

// One input channel: 2-flop synchronizer, optional debounce, data register.
// upd is high during the cycle whose ending edge loads a new value into data.
module keysw_debounce #(
    parameter int W               = 4,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] raw,
    output logic [W-1:0] data,
    output logic         upd
);
    logic [W-1:0] s1, s2;

    // two-stage synchronizer for the asynchronous raw inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

`ifdef KEYSW_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [W-1:0]  held;
    logic [CW-1:0] cnt;
    logic          stable;

    // an edge counts only if the sample matches the previous one and differs from data
    assign stable = (s2 == held) && (s2 != data);
    assign upd    = stable && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    // debounce counter: any change (or match with data) restarts from zero
    always_ff @(posedge clk) begin
        if (reset) begin
            held <= '0;
            cnt  <= '0;
        end else begin
            held <= s2;
            if (!stable || upd)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end
`else
    localparam int unused_dbc = DEBOUNCE_CYCLES;

    assign upd = (s2 != data);
`endif

    // data register follows the synchronized value once accepted
    always_ff @(posedge clk) begin
        if (reset)
            data <= '0;
        else if (upd)
            data <= s2;
    end
endmodule

module keysw_device #(
    parameter int               DBITS           = 32,
    parameter logic [DBITS-1:0] ADDRKEY         = 32'hFFFFF080,
    parameter logic [DBITS-1:0] ADDRSW          = 32'hFFFFF090,
    parameter int               DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] abus,
    input  logic [DBITS-1:0] wdata,
    input  logic             we,
    input  logic             re,
    output logic [DBITS-1:0] rdata,
    output logic             sel,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic             intr
);
    localparam logic [DBITS-1:0] ADDRKCTRL = ADDRKEY + DBITS'(4);
    localparam logic [DBITS-1:0] ADDRSCTRL = ADDRSW + DBITS'(4);

    logic [3:0] kdata;
    logic [9:0] sdata;
    logic       kupd, supd;
    logic       krdy, kovr, kie;
    logic       srdy, sovr, sie;
    logic       hit_kd, hit_kc, hit_sd, hit_sc;
    logic       krd, srd, kwr, swr;
    logic       unused_wdata;

    keysw_debounce #(.W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clk(clk), .reset(reset), .raw(~KEY), .data(kdata), .upd(kupd)
    );

    keysw_debounce #(.W(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw (
        .clk(clk), .reset(reset), .raw(SW), .data(sdata), .upd(supd)
    );

    assign hit_kd = (abus == ADDRKEY);
    assign hit_kc = (abus == ADDRKCTRL);
    assign hit_sd = (abus == ADDRSW);
    assign hit_sc = (abus == ADDRSCTRL);
    assign sel    = hit_kd | hit_kc | hit_sd | hit_sc;

    assign krd = re & hit_kd;
    assign srd = re & hit_sd;
    assign kwr = we & hit_kc;
    assign swr = we & hit_sc;

    assign unused_wdata = ^{wdata[DBITS-1:5], wdata[3], wdata[1:0]};

    // load data mux; independent of re, zero for unmapped addresses
    always_comb begin
        rdata = '0;
        if (hit_kd)
            rdata = DBITS'(kdata);
        else if (hit_kc)
            rdata = DBITS'({kie, 1'b0, kovr, 1'b0, krdy});
        else if (hit_sd)
            rdata = DBITS'(sdata);
        else if (hit_sc)
            rdata = DBITS'({sie, 1'b0, sovr, 1'b0, srdy});
    end

    // status/control bits: a data update beats a same-cycle read clear
    always_ff @(posedge clk) begin
        if (reset) begin
            krdy <= 1'b0; kovr <= 1'b0; kie <= 1'b0;
            srdy <= 1'b0; sovr <= 1'b0; sie <= 1'b0;
            intr <= 1'b0;
        end else begin
            if (kupd && krdy && !krd)  kovr <= 1'b1;
            else if (kwr && !wdata[2]) kovr <= 1'b0;
            if (kupd)     krdy <= 1'b1;
            else if (krd) krdy <= 1'b0;
            if (kwr)      kie  <= wdata[4];

            if (supd && srdy && !srd)  sovr <= 1'b1;
            else if (swr && !wdata[2]) sovr <= 1'b0;
            if (supd)     srdy <= 1'b1;
            else if (srd) srdy <= 1'b0;
            if (swr)      sie  <= wdata[4];

            intr <= (krdy & kie) | (srdy & sie);
        end
    end
endmodule

// File: tb/tb_keysw_device.sv
// Bench for keysw_device: history-window model of the debounce rule checked
// every cycle, plus directed literal expectations. Works with or without
// KEYSW_DEBOUNCE_EN (DEBOUNCE_CYCLES=4 when enabled).
`timescale 1ns/1ps
module tb_keysw_device;
    localparam logic [31:0] KD = 32'hFFFFF080;
    localparam logic [31:0] KC = 32'hFFFFF084;
    localparam logic [31:0] SD = 32'hFFFFF090;
    localparam logic [31:0] SC = 32'hFFFFF094;
`ifdef KEYSW_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif

    logic        clk = 0, reset = 1;
    logic [31:0] abus = 0, wdata = 0;
    logic        we = 0, re = 0;
    logic [31:0] rdata;
    logic        sel, intr;
    logic [3:0]  KEY = 4'hF;
    logic [9:0]  SW = '0;

    int checks = 0, errors = 0;

    keysw_device #(.DBITS(32), .ADDRKEY(KD), .ADDRSW(SD), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .abus(abus), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .sel(sel), .KEY(KEY), .SW(SW), .intr(intr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---- model: data accepts a value once the last DB+1 synchronized
    // samples (raw delayed two edges) are identical and differ from data
    logic [3:0] kh[8];
    logic [9:0] sh[8];
    logic [3:0] m_kd;
    logic [9:0] m_sd;
    logic m_krdy, m_kovr, m_kie, m_srdy, m_sovr, m_sie, m_intr;
    bit   started = 0;

    always @(posedge clk) begin : model
        bit kst, sst, kup, sup, krd, srd, nintr;
        if (reset) begin
            for (int i = 0; i < 8; i++) begin kh[i] = '0; sh[i] = '0; end
            m_kd = '0; m_sd = '0;
            m_krdy = 0; m_kovr = 0; m_kie = 0;
            m_srdy = 0; m_sovr = 0; m_sie = 0; m_intr = 0;
            started = 1;
        end else begin
            for (int i = 7; i > 0; i--) begin kh[i] = kh[i-1]; sh[i] = sh[i-1]; end
            kh[0] = ~KEY; sh[0] = SW;
            kst = 1; sst = 1;
            for (int i = 3; i <= DB + 2; i++) begin
                if (kh[i] != kh[2]) kst = 0;
                if (sh[i] != sh[2]) sst = 0;
            end
            kup = kst && (kh[2] != m_kd);
            sup = sst && (sh[2] != m_sd);
            krd = re && (abus == KD);
            srd = re && (abus == SD);
            nintr = (m_krdy && m_kie) || (m_srdy && m_sie);
            if (kup && m_krdy && !krd) m_kovr = 1;
            else if (we && abus == KC && !wdata[2]) m_kovr = 0;
            if (sup && m_srdy && !srd) m_sovr = 1;
            else if (we && abus == SC && !wdata[2]) m_sovr = 0;
            if (kup) m_krdy = 1; else if (krd) m_krdy = 0;
            if (sup) m_srdy = 1; else if (srd) m_srdy = 0;
            if (we && abus == KC) m_kie = wdata[4];
            if (we && abus == SC) m_sie = wdata[4];
            if (kup) m_kd = kh[2];
            if (sup) m_sd = sh[2];
            m_intr = nintr;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        case (a)
            KD:      return {28'd0, m_kd};
            KC:      return {27'd0, m_kie, 1'b0, m_kovr, 1'b0, m_krdy};
            SD:      return {22'd0, m_sd};
            SC:      return {27'd0, m_sie, 1'b0, m_sovr, 1'b0, m_srdy};
            default: return 32'd0;
        endcase
    endfunction

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            chk("rdata_model", rdata, exp_rd(abus));
            chk("sel_model", {31'd0, sel},
                {31'd0, (abus == KD || abus == KC || abus == SD || abus == SC)});
            chk("intr_model", {31'd0, intr}, {31'd0, m_intr});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string nm);
        abus = a; re = 0; we = 0;
        #1;
        chk(nm, rdata, exp);
    endtask

    initial begin
        reset = 1;
        repeat (3) cyc();
        reset = 0;
        peek(KD, 0, "rst_kdata");
        peek(KC, 0, "rst_kctrl");
        peek(SD, 0, "rst_sdata");
        peek(SC, 0, "rst_sctrl");
        chk("rst_intr", {31'd0, intr}, 0);
        peek(32'hFFFFF0A0, 0, "unmapped_rdata");
        chk("unmapped_sel", {31'd0, sel}, 0);
        peek(KD, 0, "mapped_rdata");
        chk("mapped_sel", {31'd0, sel}, 1);

        // SW change: data loads exactly on the (DB+3)th edge after the change
        SW = 10'h2A5;
        repeat (DB + 2) cyc();
        peek(SD, 0, "sw_before_update");
        cyc();
        peek(SD, 32'h2A5, "sw_update");
        peek(SC, 32'h1, "sctrl_rdy");
        abus = SD; re = 1;
        cyc();
        re = 0;
        peek(SC, 32'h0, "sctrl_read_clear");

        // settle to 0, clear RDY, then chatter
        SW = 10'h000;
        repeat (DB + 4) cyc();
        abus = SD; re = 1;
        cyc();
        re = 0;
        for (int i = 0; i < 10; i++) begin
            SW = (i % 2 == 0) ? 10'h001 : 10'h000;
            repeat (2) cyc();
        end
`ifdef KEYSW_DEBOUNCE_EN
        peek(SD, 0, "chatter_sdata");
        peek(SC, 0, "chatter_sctrl");
`endif
        repeat (DB + 4) cyc();

        // two key updates without a read -> overrun
        KEY = 4'b1110;
        repeat (DB + 4) cyc();
        peek(KD, 32'h1, "kdata_first");
        KEY = 4'b1100;
        repeat (DB + 4) cyc();
        peek(KD, 32'h3, "kdata_second");
        peek(KC, 32'h5, "kctrl_ovr");
        abus = KC; wdata = 32'h10; we = 1;
        cyc();
        we = 0;
        peek(KC, 32'h11, "kctrl_ie_write");
        chk("intr_before", {31'd0, intr}, 0);
        cyc();
        chk("intr_after", {31'd0, intr}, 1);

        // key update on the same edge as a KDATA load: set wins
        KEY = 4'b1000;
        repeat (DB + 2) cyc();
        peek(KD, 32'h3, "kdata_pre_same_edge");
        abus = KD; re = 1;
        cyc();
        re = 0;
        peek(KD, 32'h7, "kdata_same_edge");
        peek(KC, 32'h11, "kctrl_set_wins");

        // all-ones switches, exact latency
        SW = 10'h3FF;
        repeat (DB + 2) cyc();
        peek(SD, 0, "sw3ff_before");
        cyc();
        peek(SD, 32'h3FF, "sw3ff_update");

        // reset in the middle of a debounce discards progress
        SW = 10'h155;
        repeat (2) cyc();
        reset = 1;
        cyc();
        reset = 0;
        peek(SC, 0, "midrst_sctrl");
        chk("midrst_intr", {31'd0, intr}, 0);
        repeat (DB + 2) cyc();
        peek(SD, 0, "midrst_before");
        cyc();
        peek(SD, 32'h155, "midrst_update");

        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
